// File: rtl/btb_pkg.sv
// Shared types for the branch target buffer: per-way entry view and way selector.
package btb_pkg;

  localparam int unsigned TGT_W     = 30;
  localparam int unsigned TAG_MAX_W = 29;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [TGT_W-1:0]     target;
  } btb_entry_t;

  typedef enum logic {
    WAY0 = 1'b0,
    WAY1 = 1'b1
  } btb_way_e;

endpackage

// File: rtl/btb_lru_array.sv
// Per-set LRU bit store; bit value names the next victim way (0 = way0).
module btb_lru_array #(
  parameter int unsigned NUM_SETS = 16,
  parameter int unsigned IDX_W    = $clog2(NUM_SETS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_lk_we,
  input  logic [IDX_W-1:0]    i_lk_idx,
  input  logic                i_lk_val,
  input  logic                i_up_we,
  input  logic [IDX_W-1:0]    i_up_idx,
  input  logic                i_up_val,
  output logic [NUM_SETS-1:0] o_lru
);

  logic [NUM_SETS-1:0] r_lru;

  // Update port is written last so it wins when both ports hit the same set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lru <= '0;
    end else begin
      if (i_lk_we) r_lru[i_lk_idx] <= i_lk_val;
      if (i_up_we) r_lru[i_up_idx] <= i_up_val;
    end
  end

  assign o_lru = r_lru;

endmodule

// File: rtl/branch_target_buffer.sv
// 2-way set-associative fetch-stage BTB: combinational lookup, MEM-stage training,
// per-set LRU replacement and saturating hit/miss statistics.
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int unsigned NUM_SETS = 16,
  parameter int unsigned IDX_W    = $clog2(NUM_SETS),
  parameter int unsigned TAG_W    = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        stall,
  input  logic [31:0] pc_in,
  input  logic        load,
  input  logic [31:0] pc_mem_stage,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        hit,
  output logic [31:0] pred_target,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  logic [NUM_SETS-1:0] r_valid [2];
  logic [TAG_W-1:0]    r_tag   [2][NUM_SETS];
  logic [TGT_W-1:0]    r_tgt   [2][NUM_SETS];
  logic [31:0]         r_hit_cnt;
  logic [31:0]         r_miss_cnt;

  logic [IDX_W-1:0]    w_lk_idx, w_up_idx;
  logic [TAG_W-1:0]    w_lk_tag, w_up_tag;
  btb_entry_t          w_lk_e0, w_lk_e1, w_up_e0, w_up_e1;
  logic                w_m0, w_m1, w_um0, w_um1;
  logic                w_lk_count;
  logic                w_up_we;
  btb_way_e            w_up_way;
  logic                w_up_sel;
  logic [NUM_SETS-1:0] w_lru;
  logic                w_unused;

  assign w_lk_idx = pc_in[2+IDX_W-1:2];
  assign w_lk_tag = pc_in[31:2+IDX_W];
  assign w_up_idx = pc_mem_stage[2+IDX_W-1:2];
  assign w_up_tag = pc_mem_stage[31:2+IDX_W];
  assign w_unused = ^{pc_in[1:0], pc_mem_stage[1:0], br_target[1:0]};

  assign w_lk_e0 = '{valid: r_valid[0][w_lk_idx], tag: TAG_MAX_W'(r_tag[0][w_lk_idx]), target: r_tgt[0][w_lk_idx]};
  assign w_lk_e1 = '{valid: r_valid[1][w_lk_idx], tag: TAG_MAX_W'(r_tag[1][w_lk_idx]), target: r_tgt[1][w_lk_idx]};
  assign w_up_e0 = '{valid: r_valid[0][w_up_idx], tag: TAG_MAX_W'(r_tag[0][w_up_idx]), target: r_tgt[0][w_up_idx]};
  assign w_up_e1 = '{valid: r_valid[1][w_up_idx], tag: TAG_MAX_W'(r_tag[1][w_up_idx]), target: r_tgt[1][w_up_idx]};

  // Valid gates the tag compare, so unreset tag storage never leaks X.
  assign w_m0  = read & w_lk_e0.valid & (w_lk_e0.tag == TAG_MAX_W'(w_lk_tag));
  assign w_m1  = read & w_lk_e1.valid & (w_lk_e1.tag == TAG_MAX_W'(w_lk_tag));
  assign w_um0 = w_up_e0.valid & (w_up_e0.tag == TAG_MAX_W'(w_up_tag));
  assign w_um1 = w_up_e1.valid & (w_up_e1.tag == TAG_MAX_W'(w_up_tag));

  assign hit         = w_m0 | w_m1;
  assign pred_target = w_m0 ? {w_lk_e0.target, 2'b00} :
                       w_m1 ? {w_lk_e1.target, 2'b00} : '0;
  assign w_lk_count  = read & ~stall;

  always_comb begin
    w_up_we  = 1'b0;
    w_up_way = WAY0;
    if (load) begin
      if (w_um0) begin
        w_up_we  = 1'b1;
        w_up_way = WAY0;
      end else if (w_um1) begin
        w_up_we  = 1'b1;
        w_up_way = WAY1;
      end else if (br_taken) begin
        w_up_we = 1'b1;
        if (!w_up_e0.valid)      w_up_way = WAY0;
        else if (!w_up_e1.valid) w_up_way = WAY1;
        else                     w_up_way = btb_way_e'(w_lru[w_up_idx]);
      end
    end
  end

  assign w_up_sel = (w_up_way == WAY1);

  btb_lru_array #(
    .NUM_SETS(NUM_SETS),
    .IDX_W   (IDX_W)
  ) u_lru (
    .clk     (clk),
    .rst     (rst),
    .i_lk_we (w_lk_count & hit),
    .i_lk_idx(w_lk_idx),
    .i_lk_val(w_m0),
    .i_up_we (w_up_we),
    .i_up_idx(w_up_idx),
    .i_up_val(~w_up_sel),
    .o_lru   (w_lru)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid[0] <= '0;
      r_valid[1] <= '0;
    end else if (w_up_we) begin
      r_valid[w_up_sel][w_up_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_up_we && rst) begin
      r_tag[w_up_sel][w_up_idx] <= w_up_tag;
      r_tgt[w_up_sel][w_up_idx] <= br_target[31:2];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_lk_count) begin
      if (hit) begin
        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 32'd1;
      end else begin
        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer with a queue scoreboard of expected lookups.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        read = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] pc_in = '0;
  logic        load = 1'b0;
  logic [31:0] pc_mem_stage = '0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        hit;
  logic [31:0] pred_target;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  branch_target_buffer #(.NUM_SETS(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .read        (read),
    .stall       (stall),
    .pc_in       (pc_in),
    .load        (load),
    .pc_mem_stage(pc_mem_stage),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .hit         (hit),
    .pred_target (pred_target),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic [31:0] tgt;
    string       tag;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] e_hit = '0;
  logic [31:0] e_miss = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic h, input logic [31:0] t, input string tag);
    exp_t e;
    e.hit = h;
    e.tgt = t;
    e.tag = tag;
    q.push_back(e);
  endtask

  // Compares the current combinational lookup against the oldest expectation.
  task automatic pop_check();
    exp_t e;
    if (q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk({e.tag, ".hit"}, {31'b0, hit}, {31'b0, e.hit});
      chk({e.tag, ".tgt"}, pred_target, e.tgt);
      if (read && !stall) begin
        if (e.hit) e_hit = e_hit + 1;
        else       e_miss = e_miss + 1;
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lookup(input logic [31:0] pc, input logic h, input logic [31:0] t, input string tag);
    read  = 1'b1;
    pc_in = pc;
    push(h, t, tag);
    #1 pop_check();
    next_cycle();
    read = 1'b0;
  endtask

  task automatic update(input logic [31:0] pc, input logic tk, input logic [31:0] t);
    load         = 1'b1;
    pc_mem_stage = pc;
    br_taken     = tk;
    br_target    = t;
    next_cycle();
    load = 1'b0;
  endtask

  task automatic check_cnt(input string tag);
    chk({tag, ".hit_count"}, hit_count, e_hit);
    chk({tag, ".miss_count"}, miss_count, e_miss);
  endtask

  // Asserts reset mid-cycle and checks the asynchronous clear before the next edge.
  task automatic do_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    e_hit  = '0;
    e_miss = '0;
    chk({tag, ".rst_hit"}, {31'b0, hit}, 32'd0);
    chk({tag, ".rst_tgt"}, pred_target, 32'd0);
    check_cnt({tag, ".rst"});
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    @(negedge clk);
    do_reset("init");

    lookup(32'h0000_0060, 1'b0, 32'h0, "cold_miss");
    check_cnt("cold");
    update(32'h0000_0060, 1'b1, 32'h0000_0200);
    do_reset("midreset");
    lookup(32'h0000_0060, 1'b0, 32'h0, "cleared_by_reset");

    update(32'h0000_0060, 1'b1, 32'h0000_0200);
    lookup(32'h0000_0060, 1'b1, 32'h0000_0200, "install_hit");
    lookup(32'h0000_0063, 1'b1, 32'h0000_0200, "low_bits_ignored");
    update(32'h0000_1000, 1'b1, 32'h0000_1237);
    lookup(32'h0000_1000, 1'b1, 32'h0000_1234, "target_low_zero");
    lookup(32'h0000_2000, 1'b0, 32'h0, "other_tag_miss");
    check_cnt("basic");

    do_reset("evict");
    update(32'h0000_0060, 1'b1, 32'h0000_0A00);
    update(32'h0000_0460, 1'b1, 32'h0000_0B00);
    update(32'h0000_0860, 1'b1, 32'h0000_0C00);
    lookup(32'h0000_0060, 1'b0, 32'h0, "evict_oldest");
    lookup(32'h0000_0460, 1'b1, 32'h0000_0B00, "evict_keep_b");
    lookup(32'h0000_0860, 1'b1, 32'h0000_0C00, "evict_new_c");

    do_reset("lru");
    update(32'h0000_0060, 1'b1, 32'h0000_0A00);
    update(32'h0000_0460, 1'b1, 32'h0000_0B00);
    lookup(32'h0000_0060, 1'b1, 32'h0000_0A00, "lru_touch_a");
    update(32'h0000_0860, 1'b1, 32'h0000_0C00);
    lookup(32'h0000_0460, 1'b0, 32'h0, "lru_evict_b");
    lookup(32'h0000_0060, 1'b1, 32'h0000_0A00, "lru_keep_a");
    lookup(32'h0000_0860, 1'b1, 32'h0000_0C00, "lru_new_c");
    check_cnt("lru");

    update(32'h0000_0100, 1'b0, 32'h0000_0500);
    lookup(32'h0000_0100, 1'b0, 32'h0, "nt_absent");
    update(32'h0000_0060, 1'b0, 32'h0000_0300);
    lookup(32'h0000_0060, 1'b1, 32'h0000_0300, "nt_retarget");

    load         = 1'b1;
    pc_mem_stage = 32'h0000_0060;
    br_taken     = 1'b1;
    br_target    = 32'h0000_0400;
    read         = 1'b1;
    pc_in        = 32'h0000_0060;
    push(1'b1, 32'h0000_0300, "same_cycle_old");
    #1 pop_check();
    next_cycle();
    load = 1'b0;
    push(1'b1, 32'h0000_0400, "same_cycle_new");
    #1 pop_check();
    next_cycle();
    read = 1'b0;
    check_cnt("same_cycle");

    stall = 1'b1;
    read  = 1'b1;
    pc_in = 32'h0000_0060;
    for (int i = 0; i < 5; i++) begin
      push(1'b1, 32'h0000_0400, "stalled_lookup");
      #1 pop_check();
      next_cycle();
    end
    stall = 1'b0;
    read  = 1'b0;
    check_cnt("stall");

    chk("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
